cmd_frame_decoder: RTL
======================

# cmd_frame_decoder

Parametrised command-frame decoder for the core-switch board, placed between the UART receive FIFO and the CPU switch, reset and power logic. It parses 8-byte control-centre frames, validates header, checksum and trailer, and drives host selection, per-CPU reset pulses, per-CPU power control and debug mode for `NUM_CPU` CPUs. It replaces the fixed two-CPU decoder with a byte-streaming parser that has an inter-byte timeout and resynchronisation.

## Interface
- `NUM_CPU`, 2: number of CPUs, 2..4. `SELW` = 2 (derived).
- `BOARD_ID`, 8'hAB: board ID byte that frames must carry to be acted on.
- `RESET_CYCLES`, 1000: length of a CPU reset pulse in clk cycles, at least 1.
- `TIMEOUT_CYCLES`, 5000: maximum idle clk cycles between bytes of one frame.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `rx_valid`  in  1  `rx_data` is valid this cycle; one byte per cycle is accepted
- `rx_data`  in  8  received byte
- `host_cur`  in  SELW  index of the CPU currently acting as host
- `host_sel`  out  SELW  commanded host index
- `swi_pulse`  out  1  one-cycle strobe: apply `host_sel`
- `reset_cpu`  out  NUM_CPU  active-high CPU reset, RESET_CYCLES long
- `power_on`  out  NUM_CPU  commanded power state
- `power_force`  out  NUM_CPU  one-cycle strobe: apply `power_on[n]`
- `debug_mode`  out  1  debug mode level
- `frame_ok`  out  1  one-cycle strobe: valid frame addressed to this board
- `frame_err`  out  1  one-cycle strobe: bad header, checksum, trailer or timeout
- `tx_valid`  out  1  echo strobe (see Configuration)
- `tx_data`  out  8  echo byte

## Operation
- Frame layout, bytes B0..B7: EB 90 ID CMD ARG CSUM 09 D7.
- Frame is valid when (B2+B3+B4+B5) mod 256 == 0, B6 == 09 and B7 == D7.
- Parser states:
  - IDLE: waiting for EB; any other byte is discarded silently.
  - HDR2: next byte must be 90. If it is EB, pulse `frame_err` and stay in HDR2. Any other byte: pulse `frame_err` and go to IDLE.
  - BODY: byte counter 2..7. An 8-bit running sum accumulates B2..B5. B2..B4 are stored.
- Frame end: the B7 acceptance performs the check and execution in that same cycle, then returns to IDLE. There is no dead cycle, so a new EB may follow immediately.
- Timeout: in HDR2 or BODY, if `TIMEOUT_CYCLES` consecutive cycles pass without `rx_valid`, pulse `frame_err` and go to IDLE.
- Failed check: pulse `frame_err`; no other effect.
- Valid frame with ID ≠ BOARD_ID: no pulse, no effect.
- Valid frame with ID = BOARD_ID: pulse `frame_ok` and execute CMD. In the commands below, n = CMD[3:0].
  - 0x0n: `host_sel`←n, pulse `swi_pulse`.
  - 0x1n: if n ≠ `host_cur`, start reset of CPU n.
  - 0x2n: `power_on[n]`←1, pulse `power_force[n]`.
  - 0x3n: if n ≠ `host_cur`, `power_on[n]`←0, pulse `power_force[n]`.
  - 0x40: `debug_mode`←1. 0x41: `debug_mode`←0.
  - Any other CMD, or n ≥ NUM_CPU: `frame_ok` still pulses, no state change. ARG is reserved.
- Reset generator: one counter per CPU. A start sets `reset_cpu[n]` and loads the counter. A start while the reset is active reloads the counter (retrigger).

## Timing
- Reset values: `host_sel`=0, `swi_pulse`=0, `reset_cpu`=0, `power_on`=1 on bit 0 only, `power_force`=0, `debug_mode`=0, `frame_ok`=0, `frame_err`=0, `tx_valid`=0. Parser goes to IDLE; counters clear.
- `rst` mid-frame discards the partial frame and terminates any active CPU reset immediately.
- Latency: all outputs are registered. Strobes and level changes are visible in the cycle after the edge that samples B7 (or the offending byte).
- `reset_cpu[n]` stays high for exactly RESET_CYCLES cycles, starting the cycle after B7.
- Timeout flags on the cycle after the TIMEOUT_CYCLES-th idle cycle. The idle counter clears on every accepted byte.
- Every strobe is exactly one cycle wide. Strobes are never stretched by back-to-back frames.

## Configuration
- `CMD_ECHO_EN` defined: every accepted byte is echoed one cycle later on `tx_data` with `tx_valid`=1, regardless of parser state. This forwards frames to the host CPU.
- `CMD_ECHO_EN` undefined: `tx_valid` is tied 0 and `tx_data` is tied 8'h00; no echo register is built.

## Test plan
- Frame EB 90 AB 01 00 54 09 D7, back-to-back valid → `host_sel`=1 and `swi_pulse` one cycle, 1 cycle after B7; `frame_ok` pulses.
- Same frame with CSUM 55 → `frame_err` pulses once; `host_sel` and `swi_pulse` unchanged.
- `host_cur`=0, frame CMD 11 (CSUM 44); then CMD 10 (CSUM 45) → `reset_cpu[1]` high exactly RESET_CYCLES cycles; CMD 10 is refused and `reset_cpu[0]` stays 0.
- Stream EB EB 90 AB 40 00 15 09 D7 → one `frame_err` pulse for the second EB, then `debug_mode`=1 with `frame_ok`.
- EB 90 AB followed by TIMEOUT_CYCLES idle cycles → `frame_err` pulses once; a following valid frame still decodes correctly.
- Mid-frame `rst` → all outputs return to reset values; the remainder of the frame produces no effect.

Source files
------------

// File: rtl/cmd_frame_decoder.sv
// cmd_frame_decoder: byte-streaming parser for 8-byte control-centre frames
// (EB 90 ID CMD ARG CSUM 09 D7). It validates the header, checksum and trailer,
// then drives host selection, per-CPU reset pulses, per-CPU power control and
// debug mode.
//
// Optional feature macro: CMD_ECHO_EN. When it is defined, every accepted byte
// is echoed one cycle later on tx_valid/tx_data.
//
// Ports:
//   clk, rst              system clock; synchronous active-high reset
//   rx_valid, rx_data     incoming byte stream, one byte per cycle
//   host_cur              index of the CPU currently acting as host
//   host_sel, swi_pulse   commanded host index and its apply strobe
//   reset_cpu             per-CPU reset, RESET_CYCLES long
//   power_on, power_force per-CPU power level and its apply strobe
//   debug_mode            debug mode level
//   frame_ok, frame_err   frame result strobes
//   tx_valid, tx_data     byte echo (CMD_ECHO_EN only, otherwise tied 0)
module cmd_frame_decoder #(
   parameter int unsigned NUM_CPU        = 2,
   parameter logic [7:0]  BOARD_ID       = 8'hAB,
   parameter int unsigned RESET_CYCLES   = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 5000,
   localparam int unsigned SELW          = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rx_valid,
   input  logic [7:0]         rx_data,
   input  logic [SELW-1:0]    host_cur,
   output logic [SELW-1:0]    host_sel,
   output logic               swi_pulse,
   output logic [NUM_CPU-1:0] reset_cpu,
   output logic [NUM_CPU-1:0] power_on,
   output logic [NUM_CPU-1:0] power_force,
   output logic               debug_mode,
   output logic               frame_ok,
   output logic               frame_err,
   output logic               tx_valid,
   output logic [7:0]         tx_data
);

   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR2,
      ST_BODY
   } state_t;

   state_t             state, state_nxt;
   logic [2:0]         bcnt, bcnt_nxt;
   logic [7:0]         sum, sum_nxt;
   logic [7:0]         id_q, id_nxt;
   logic [7:0]         cmd_q, cmd_nxt;
   logic               b6_ok, b6_ok_nxt;
   logic [TW-1:0]      idle_cnt, idle_nxt;

   logic [SELW-1:0]    host_sel_nxt;
   logic               swi_nxt;
   logic [NUM_CPU-1:0] power_on_nxt;
   logic [NUM_CPU-1:0] force_nxt;
   logic               debug_nxt;
   logic               ok_nxt;
   logic               err_nxt;
   logic [NUM_CPU-1:0] rst_start;

   logic [RW-1:0]      rcnt [NUM_CPU];

   logic [3:0]         n_idx;
   logic               n_in_range;
   logic               n_not_host;
   logic               timeout;

   assign n_idx      = cmd_q[3:0];
   assign n_in_range = n_idx < 4'(NUM_CPU);
   assign n_not_host = n_idx != 4'(host_cur);
   // Last allowed idle cycle ends the partial frame.
   assign timeout    = !rx_valid && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         bcnt        <= 3'd0;
         sum         <= 8'h00;
         id_q        <= 8'h00;
         cmd_q       <= 8'h00;
         b6_ok       <= 1'b0;
         idle_cnt    <= '0;
         host_sel    <= '0;
         swi_pulse   <= 1'b0;
         power_on    <= NUM_CPU'(1);
         power_force <= '0;
         debug_mode  <= 1'b0;
         frame_ok    <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         state       <= state_nxt;
         bcnt        <= bcnt_nxt;
         sum         <= sum_nxt;
         id_q        <= id_nxt;
         cmd_q       <= cmd_nxt;
         b6_ok       <= b6_ok_nxt;
         idle_cnt    <= idle_nxt;
         host_sel    <= host_sel_nxt;
         swi_pulse   <= swi_nxt;
         power_on    <= power_on_nxt;
         power_force <= force_nxt;
         debug_mode  <= debug_nxt;
         frame_ok    <= ok_nxt;
         frame_err   <= err_nxt;
      end
   end

   // Parser next-state, frame check and command execution.
   always_comb begin
      state_nxt    = state;
      bcnt_nxt     = bcnt;
      sum_nxt      = sum;
      id_nxt       = id_q;
      cmd_nxt      = cmd_q;
      b6_ok_nxt    = b6_ok;
      idle_nxt     = rx_valid ? '0 : TW'(idle_cnt + 1'b1);
      host_sel_nxt = host_sel;
      swi_nxt      = 1'b0;
      power_on_nxt = power_on;
      force_nxt    = '0;
      debug_nxt    = debug_mode;
      ok_nxt       = 1'b0;
      err_nxt      = 1'b0;
      rst_start    = '0;

      case (state)
         ST_IDLE: begin
            idle_nxt = '0;
            if (rx_valid && rx_data == 8'hEB) begin
               state_nxt = ST_HDR2;
            end
         end

         ST_HDR2: begin
            if (rx_valid) begin
               if (rx_data == 8'h90) begin
                  state_nxt = ST_BODY;
                  bcnt_nxt  = 3'd2;
                  sum_nxt   = 8'h00;
               end else if (rx_data == 8'hEB) begin
                  // A repeated sync byte may be the start of the real frame.
                  err_nxt = 1'b1;
               end else begin
                  err_nxt   = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end else if (timeout) begin
               err_nxt   = 1'b1;
               state_nxt = ST_IDLE;
               idle_nxt  = '0;
            end
         end

         ST_BODY: begin
            if (rx_valid) begin
               bcnt_nxt = 3'(bcnt + 3'd1);
               case (bcnt)
                  3'd2: begin
                     id_nxt  = rx_data;
                     sum_nxt = 8'(sum + rx_data);
                  end
                  3'd3: begin
                     cmd_nxt = rx_data;
                     sum_nxt = 8'(sum + rx_data);
                  end
                  3'd4, 3'd5: sum_nxt = 8'(sum + rx_data);
                  3'd6: b6_ok_nxt = (rx_data == 8'h09);
                  3'd7: begin
                     // Check and execute on the final byte; no dead cycle.
                     state_nxt = ST_IDLE;
                     if (sum == 8'h00 && b6_ok && rx_data == 8'hD7) begin
                        if (id_q == BOARD_ID) begin
                           ok_nxt = 1'b1;
                           case (cmd_q[7:4])
                              4'h0: begin
                                 if (n_in_range) begin
                                    host_sel_nxt = SELW'(n_idx);
                                    swi_nxt      = 1'b1;
                                 end
                              end
                              4'h1: begin
                                 for (int i = 0; i < NUM_CPU; i++) begin
                                    if (4'(i) == n_idx && n_not_host) rst_start[i] = 1'b1;
                                 end
                              end
                              4'h2: begin
                                 for (int i = 0; i < NUM_CPU; i++) begin
                                    if (4'(i) == n_idx) begin
                                       power_on_nxt[i] = 1'b1;
                                       force_nxt[i]    = 1'b1;
                                    end
                                 end
                              end
                              4'h3: begin
                                 for (int i = 0; i < NUM_CPU; i++) begin
                                    if (4'(i) == n_idx && n_not_host) begin
                                       power_on_nxt[i] = 1'b0;
                                       force_nxt[i]    = 1'b1;
                                    end
                                 end
                              end
                              4'h4: begin
                                 if (n_idx == 4'h0) debug_nxt = 1'b1;
                                 else if (n_idx == 4'h1) debug_nxt = 1'b0;
                              end
                              default: ;
                           endcase
                        end
                     end else begin
                        err_nxt = 1'b1;
                     end
                  end
                  default: state_nxt = ST_IDLE;
               endcase
            end else if (timeout) begin
               err_nxt   = 1'b1;
               state_nxt = ST_IDLE;
               idle_nxt  = '0;
            end
         end

         default: state_nxt = ST_IDLE;
      endcase
   end

   // Per-CPU reset pulse generators; a new start reloads the counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         reset_cpu <= '0;
         for (int i = 0; i < NUM_CPU; i++) rcnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CPU; i++) begin
            if (rst_start[i]) begin
               reset_cpu[i] <= 1'b1;
               rcnt[i]      <= RW'(RESET_CYCLES - 1);
            end else if (reset_cpu[i]) begin
               if (rcnt[i] == '0) reset_cpu[i] <= 1'b0;
               else rcnt[i] <= RW'(rcnt[i] - 1'b1);
            end
         end
      end
   end

`ifdef CMD_ECHO_EN
   // Forward every accepted byte to the host one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         tx_valid <= rx_valid;
         if (rx_valid) tx_data <= rx_data;
      end
   end
`else
   assign tx_valid = 1'b0;
   assign tx_data  = 8'h00;
`endif

endmodule
